alu_result_queue: RTL and testbench
===================================

// Module: alu_result_queue
// PURPOSE
//  Downstream stage of the 8-bit ALU/flag mux. Captures each ALU result tuple
//  (ctrl opcode, result s, 12-bit flags) into a DEPTH-entry FIFO and presents
//  the tuples in order to a consumer over a valid/ready handshake.
//  Also keeps sticky flags, an accepted-operation counter and a dropped-write
//  counter for the test and debug benches.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >= 2
//  CNT_W   8   width of op_count and drop_count
// PORTS
//  clk           in   1      single clock; all state updates on rising edge
//  reset         in   1      synchronous, active-high; clears all state
//  in_valid      in   1      upstream tuple valid this cycle
//  in_ready      out  1      = !full; tuple accepted when in_valid & in_ready
//  in_ctrl       in   4      ALU opcode that produced the tuple
//  in_s          in   8      ALU result
//  in_flags      in   12     ALU flags vector (opaque; bitwise only)
//  out_valid     out  1      = !empty; head tuple on out_* is valid
//  out_ready     in   1      consumer pops head when out_valid & out_ready
//  out_ctrl      out  4      head opcode
//  out_s         out  8      head result
//  out_flags     out  12     head flags
//  sticky_flags  out  12     OR of in_flags over all accepted pushes since clear
//  clr_sticky    in   1      clears sticky_flags
//  occupancy     out  log2(DEPTH)+1  entries currently held
//  op_count      out  CNT_W  accepted pushes, wraps modulo 2^CNT_W
//  drop_count    out  CNT_W  in_valid while !in_ready; saturates at all-ones
// BEHAVIOUR
//  - Reset values: occupancy=0, rd/wr pointers=0, out_valid=0, in_ready=1,
//    sticky_flags=0, op_count=0, drop_count=0. out_ctrl/out_s/out_flags=0
//    while empty. Storage contents are don't-care.
//  - Reset mid-operation discards all queued tuples. A push or pop in the
//    reset cycle is ignored. Counters restart at 0.
//  - Show-ahead FIFO. Head data is driven from storage at the read pointer.
//    Push at edge N makes out_valid=1 after edge N: one-cycle latency.
//    There is no combinational path from in_* to out_*.
//  - Occupancy states: EMPTY(0), PARTIAL(1..DEPTH-1), FULL(DEPTH).
//      push only : occupancy+1, wr_ptr+1
//      pop only  : occupancy-1, rd_ptr+1
//      push & pop same cycle (PARTIAL only): occupancy unchanged, both
//        pointers advance, order preserved.
//      EMPTY: a pop is impossible (out_valid=0); a push goes to PARTIAL.
//      FULL: in_ready=0, so a push is never accepted, even with a
//        simultaneous pop. in_ready rises the cycle after the pop.
//  - Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//  - Drop: in_valid & !in_ready increments drop_count once per cycle,
//    saturating. The tuple is lost and sticky/op_count are unchanged.
//  - Sticky: on an accepted push, sticky_flags <= sticky_flags | in_flags.
//    clr_sticky without a push: sticky_flags <= 0.
//    clr_sticky with a push: sticky_flags <= in_flags (clear, then OR).
//  - op_count increments on every accepted push and wraps (0xFF -> 0x00).
//  - in_ready, out_valid and occupancy are registered-state derived only,
//    with no dependence on same-cycle in_valid/out_ready.
// TESTING
//  1 reset, push ctrl=4'h0 s=8'h85 flags=12'h001 -> next cycle out_valid=1,
//    out_s=8'h85, sticky_flags=12'h001, op_count=1
//  2 push 4 tuples s=8'h11,22,33,44 with out_ready=0 -> occupancy=4, in_ready=0;
//    5th push s=8'h55 -> drop_count=1; pops return 11,22,33,44 in order
//  3 occupancy=2, push s=8'hAA and pop in the same cycle -> occupancy stays 2,
//    head advances, 8'hAA emerges after the older entry
//  4 stream 10 tuples s=8'h01..0A with out_ready=1 every cycle -> all 10 out in
//    order across pointer wrap, drop_count=0, op_count=10
//  5 push flags 12'h010 then 12'h800 -> sticky=12'h810; clr_sticky together
//    with a push of flags 12'h004 -> sticky=12'h004
//  6 after 3 pushes assert reset for 1 cycle with in_valid=1 -> occupancy=0,
//    out_valid=0, op_count=0, sticky_flags=0

Source files
------------

// File: rtl/alu_result_queue.sv
// Show-ahead FIFO for ALU result tuples with valid/ready handshakes on both sides,
// plus sticky flags, an accepted-push counter and a saturating dropped-write counter.
module alu_result_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_ctrl,
   input  logic [7:0]               in_s,
   input  logic [11:0]              in_flags,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_ctrl,
   output logic [7:0]               out_s,
   output logic [11:0]              out_flags,
   output logic [11:0]              sticky_flags,
   input  logic                     clr_sticky,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_W-1:0]         op_count,
   output logic [CNT_W-1:0]         drop_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [7:0]  s;
      logic [11:0] flags;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               push_c;
   logic               pop_c;
   entry_t             head_c;

   // Handshake status decodes only registered occupancy.
   assign in_ready  = (occupancy != OCC_W'(DEPTH));
   assign out_valid = (occupancy != '0);
   assign push_c    = in_valid & in_ready;
   assign pop_c     = out_valid & out_ready;

   // Head is zeroed while empty so stale storage never leaks out.
   assign head_c    = out_valid ? mem[rd_ptr] : '0;
   assign out_ctrl  = head_c.ctrl;
   assign out_s     = head_c.s;
   assign out_flags = head_c.flags;

   // Storage needs no reset; only the pointers and occupancy qualify it.
   always_ff @(posedge clk) begin
      if (!reset && push_c) begin
         mem[wr_ptr] <= '{ctrl: in_ctrl, s: in_s, flags: in_flags};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Sticky flags: clear takes effect before the same-cycle push is ORed in.
   always_ff @(posedge clk) begin
      if (reset) begin
         sticky_flags <= '0;
      end else if (clr_sticky) begin
         sticky_flags <= push_c ? in_flags : 12'h000;
      end else if (push_c) begin
         sticky_flags <= sticky_flags | in_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_count   <= '0;
         drop_count <= '0;
      end else begin
         if (push_c) op_count <= op_count + CNT_W'(1);
         if (in_valid && !in_ready && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: vector table for the single-cycle behaviour,
// hand sequences for simultaneous push/pop, streaming, wrap, saturation and reset.
module tb_alu_result_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_ctrl;
   logic [7:0]  in_s;
   logic [11:0] in_flags;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_ctrl;
   logic [7:0]  out_s;
   logic [11:0] out_flags;
   logic [11:0] sticky_flags;
   logic        clr_sticky;
   logic [2:0]  occupancy;
   logic [7:0]  op_count;
   logic [7:0]  drop_count;

   int n_chk  = 0;
   int n_fail = 0;

   alu_result_queue #(.DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_s(in_s), .in_flags(in_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_s(out_s), .out_flags(out_flags),
      .sticky_flags(sticky_flags), .clr_sticky(clr_sticky),
      .occupancy(occupancy), .op_count(op_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        iv;
      logic [3:0]  ctrl;
      logic [7:0]  s;
      logic [11:0] fl;
      logic        ordy;
      logic        clr;
      logic [2:0]  e_occ;
      logic [3:0]  e_ctrl;
      logic [7:0]  e_s;
      logic [11:0] e_fl;
      logic [11:0] e_st;
      logic [7:0]  e_opc;
      logic [7:0]  e_drop;
   } vec_t;

   vec_t vecs [19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [3:0] c, input logic [7:0] s,
                        input logic [11:0] f, input logic ordy, input logic clr);
      reset = r; in_valid = iv; in_ctrl = c; in_s = s; in_flags = f;
      out_ready = ordy; clr_sticky = clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int got;
      int sent;
      drive(1'b1, 1'b0, 4'h0, 8'h00, 12'h000, 1'b0, 1'b0);

      //          rst iv ctrl  s      fl       ordy clr  occ  ctrl  s      fl       st       opc    drop
      vecs[0]  = '{1'b1,1'b0,4'h0,8'h00,12'h000,1'b0,1'b0,3'd0,4'h0,8'h00,12'h000,12'h000,8'd0,8'd0};
      vecs[1]  = '{1'b0,1'b1,4'h0,8'h85,12'h001,1'b0,1'b0,3'd1,4'h0,8'h85,12'h001,12'h001,8'd1,8'd0};
      vecs[2]  = '{1'b0,1'b0,4'h0,8'h00,12'h000,1'b1,1'b0,3'd0,4'h0,8'h00,12'h000,12'h001,8'd1,8'd0};
      vecs[3]  = '{1'b0,1'b1,4'h1,8'h11,12'h002,1'b0,1'b0,3'd1,4'h1,8'h11,12'h002,12'h003,8'd2,8'd0};
      vecs[4]  = '{1'b0,1'b1,4'h2,8'h22,12'h000,1'b0,1'b0,3'd2,4'h1,8'h11,12'h002,12'h003,8'd3,8'd0};
      vecs[5]  = '{1'b0,1'b1,4'h3,8'h33,12'h000,1'b0,1'b0,3'd3,4'h1,8'h11,12'h002,12'h003,8'd4,8'd0};
      vecs[6]  = '{1'b0,1'b1,4'h4,8'h44,12'h000,1'b0,1'b0,3'd4,4'h1,8'h11,12'h002,12'h003,8'd5,8'd0};
      vecs[7]  = '{1'b0,1'b1,4'h5,8'h55,12'h400,1'b0,1'b0,3'd4,4'h1,8'h11,12'h002,12'h003,8'd5,8'd1};
      vecs[8]  = '{1'b0,1'b1,4'h6,8'h66,12'h400,1'b1,1'b0,3'd3,4'h2,8'h22,12'h000,12'h003,8'd5,8'd2};
      vecs[9]  = '{1'b0,1'b0,4'h0,8'h00,12'h000,1'b1,1'b0,3'd2,4'h3,8'h33,12'h000,12'h003,8'd5,8'd2};
      vecs[10] = '{1'b0,1'b0,4'h0,8'h00,12'h000,1'b1,1'b0,3'd1,4'h4,8'h44,12'h000,12'h003,8'd5,8'd2};
      vecs[11] = '{1'b0,1'b0,4'h0,8'h00,12'h000,1'b1,1'b0,3'd0,4'h0,8'h00,12'h000,12'h003,8'd5,8'd2};
      vecs[12] = '{1'b0,1'b0,4'h0,8'h00,12'h000,1'b0,1'b1,3'd0,4'h0,8'h00,12'h000,12'h000,8'd5,8'd2};
      vecs[13] = '{1'b0,1'b1,4'hA,8'h5A,12'h010,1'b0,1'b0,3'd1,4'hA,8'h5A,12'h010,12'h010,8'd6,8'd2};
      vecs[14] = '{1'b0,1'b1,4'hB,8'h5B,12'h800,1'b0,1'b0,3'd2,4'hA,8'h5A,12'h010,12'h810,8'd7,8'd2};
      vecs[15] = '{1'b0,1'b1,4'hC,8'h5C,12'h004,1'b0,1'b1,3'd3,4'hA,8'h5A,12'h010,12'h004,8'd8,8'd2};
      vecs[16] = '{1'b0,1'b0,4'h0,8'h00,12'h000,1'b1,1'b0,3'd2,4'hB,8'h5B,12'h800,12'h004,8'd8,8'd2};
      vecs[17] = '{1'b0,1'b0,4'h0,8'h00,12'h000,1'b1,1'b0,3'd1,4'hC,8'h5C,12'h004,12'h004,8'd8,8'd2};
      vecs[18] = '{1'b0,1'b0,4'h0,8'h00,12'h000,1'b1,1'b0,3'd0,4'h0,8'h00,12'h000,12'h004,8'd8,8'd2};

      #1;
      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].rst, vecs[i].iv, vecs[i].ctrl, vecs[i].s, vecs[i].fl, vecs[i].ordy, vecs[i].clr);
         step();
         chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
         chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_occ != 3'd0));
         chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_occ != 3'd4));
         chk($sformatf("v%0d out_ctrl", i), 32'(out_ctrl), 32'(vecs[i].e_ctrl));
         chk($sformatf("v%0d out_s", i), 32'(out_s), 32'(vecs[i].e_s));
         chk($sformatf("v%0d out_flags", i), 32'(out_flags), 32'(vecs[i].e_fl));
         chk($sformatf("v%0d sticky", i), 32'(sticky_flags), 32'(vecs[i].e_st));
         chk($sformatf("v%0d op_count", i), 32'(op_count), 32'(vecs[i].e_opc));
         chk($sformatf("v%0d drop_count", i), 32'(drop_count), 32'(vecs[i].e_drop));
      end

      // Simultaneous push and pop at occupancy 2
      drive(1'b0, 1'b1, 4'h1, 8'hC1, 12'h000, 1'b0, 1'b0); step();
      drive(1'b0, 1'b1, 4'h2, 8'hC2, 12'h000, 1'b0, 1'b0); step();
      chk("pp pre occupancy", 32'(occupancy), 32'd2);
      drive(1'b0, 1'b1, 4'h7, 8'hAA, 12'h000, 1'b1, 1'b0); step();
      chk("pp occupancy", 32'(occupancy), 32'd2);
      chk("pp head", 32'(out_s), 32'hC2);
      drive(1'b0, 1'b0, 4'h0, 8'h00, 12'h000, 1'b1, 1'b0); step();
      chk("pp second head", 32'(out_s), 32'hAA);
      chk("pp second ctrl", 32'(out_ctrl), 32'h7);
      drive(1'b0, 1'b0, 4'h0, 8'h00, 12'h000, 1'b1, 1'b0); step();
      chk("pp drained", 32'(occupancy), 32'd0);
      chk("pp op_count", 32'(op_count), 32'd11);

      // Stream 10 tuples with the consumer always ready, across pointer wrap
      got = 0; sent = 0;
      for (int c = 0; c < 40 && got < 10; c++) begin
         drive(1'b0, sent < 10, 4'h0, 8'(sent + 1), 12'h000, 1'b1, 1'b0);
         if (out_valid) begin
            chk($sformatf("stream out %0d", got), 32'(out_s), 32'(got + 1));
            got++;
         end
         if (in_valid && in_ready) sent++;
         step();
      end
      chk("stream count", 32'(got), 32'd10);
      chk("stream drop_count", 32'(drop_count), 32'd2);
      chk("stream op_count", 32'(op_count), 32'd21);
      chk("stream occupancy", 32'(occupancy), 32'd0);

      // op_count wraps from 0xFF to 0x00 after 235 further pushes
      for (int c = 0; c < 235; c++) begin
         drive(1'b0, 1'b1, 4'h0, 8'h01, 12'h000, 1'b1, 1'b0); step();
      end
      drive(1'b0, 1'b0, 4'h0, 8'h00, 12'h000, 1'b1, 1'b0); step();
      chk("wrap op_count", 32'(op_count), 32'd0);
      chk("wrap occupancy", 32'(occupancy), 32'd0);

      // drop_count saturates while full
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 1'b1, 4'h0, 8'(c), 12'h000, 1'b0, 1'b0); step();
      end
      for (int c = 0; c < 260; c++) begin
         drive(1'b0, 1'b1, 4'h0, 8'hEE, 12'h020, 1'b0, 1'b0); step();
      end
      chk("sat drop_count", 32'(drop_count), 32'hFF);
      chk("sat op_count", 32'(op_count), 32'd4);
      chk("sat in_ready", 32'(in_ready), 32'd0);
      chk("sat sticky", 32'(sticky_flags), 32'h004);

      // Reset mid-operation with in_valid asserted discards everything
      drive(1'b1, 1'b0, 4'h0, 8'h00, 12'h000, 1'b0, 1'b0); step();
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b1, 4'h3, 8'(8'h70 + c), 12'h0F0, 1'b0, 1'b0); step();
      end
      chk("rst pre occupancy", 32'(occupancy), 32'd3);
      chk("rst pre sticky", 32'(sticky_flags), 32'h0F0);
      drive(1'b1, 1'b1, 4'h3, 8'h99, 12'h00F, 1'b1, 1'b0); step();
      chk("rst occupancy", 32'(occupancy), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst op_count", 32'(op_count), 32'd0);
      chk("rst drop_count", 32'(drop_count), 32'd0);
      chk("rst sticky", 32'(sticky_flags), 32'h000);
      chk("rst out_s", 32'(out_s), 32'h00);
      drive(1'b0, 1'b1, 4'h5, 8'h77, 12'h100, 1'b0, 1'b0); step();
      chk("post rst occupancy", 32'(occupancy), 32'd1);
      chk("post rst head", 32'(out_s), 32'h77);
      chk("post rst op_count", 32'(op_count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
